// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA decryption core: FSM states, default operand width
// and helpers for counter sizing and start-to-Done latency (RSA_CONST_TIME_EN aware).
package rsa_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REDUCE,
        MUL,
        SQR,
        FIN
    } state_t;

    // Bits needed to count 0..width-1.
    function automatic int cnt_width(input int width);
        return (width < 3) ? 1 : $clog2(width);
    endfunction

    // Edge index L after which Done is high, counted from the launch edge (edge 0).
    function automatic int done_latency(input int width, input int key_pop,
                                        input bit n_small, input bit const_time);
        int mul_ops;
        if (n_small)
            return 2;
        mul_ops = const_time ? width : key_pop;
        return 2 + (width + 1) * (1 + width + mul_ops);
    endfunction

endpackage

// File: rtl/rsa_decrypt_mod_mul.sv
// Bit-serial modular multiplier p = a*b mod N, MSB of a first; the first bit step
// happens on the go edge so rdy pulses WIDTH cycles after go. Requires b < N, WIDTH >= 2.
module mod_mul
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] p,
    output logic             rdy
);

    localparam int AW = WIDTH + 2;
    localparam int CW = cnt_width(WIDTH);

    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [CW-1:0]    steps_left;

    // acc < N and b < N keep the sum below 3N, so two subtractions restore acc < N.
    function automatic logic [AW-1:0] step(input logic [AW-1:0]    acc_in,
                                           input logic             a_bit,
                                           input logic [WIDTH-1:0] b_in,
                                           input logic [WIDTH-1:0] n_in);
        logic [AW-1:0] t;
        logic [AW-1:0] n_ext;
        // NOTE: blocking assignments are right here: t is a function-local temporary.
        n_ext = {2'b00, n_in};
        t     = {acc_in[AW-2:0], 1'b0} + (a_bit ? {2'b00, b_in} : '0);
        if (t >= n_ext)
            t = t - n_ext;
        if (t >= n_ext)
            t = t - n_ext;
        return t;
    endfunction

    assign acc_nxt = go ? step('0, a[WIDTH-1], b, N)
                        : step(acc, a_sh[WIDTH-1], b_q, n_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            a_sh       <= '0;
            b_q        <= '0;
            n_q        <= '0;
            steps_left <= '0;
            rdy        <= 1'b0;
        end else begin
            rdy <= 1'b0;
            if (go) begin
                acc        <= acc_nxt;
                a_sh       <= {a[WIDTH-2:0], 1'b0};
                b_q        <= b;
                n_q        <= N;
                steps_left <= CW'(WIDTH - 1);
            end else if (steps_left != '0) begin
                acc        <= acc_nxt;
                a_sh       <= {a_sh[WIDTH-2:0], 1'b0};
                steps_left <= steps_left - 1'b1;
                rdy        <= (steps_left == CW'(1));
            end
        end
    end

    assign p = acc[WIDTH-1:0];

endmodule

// File: rtl/rsa_decrypt.sv
// RSA decryption core: result = data^key mod N by right-to-left square-and-multiply
// on one shared mod_mul. Define RSA_CONST_TIME_EN for key-independent latency.
module rsa_decrypt
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] key,
    output logic [WIDTH-1:0] result,
    output logic             Done,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic             start_q;
    logic             issued;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] key_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] base;
    logic [CW-1:0]    bit_idx;

    logic             launch;
    logic             mm_go;
    logic             mm_rdy;
    logic             op_done;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_p;
    logic             run_mul_now;
    logic             run_mul_next;

`ifdef RSA_CONST_TIME_EN
    // Every key bit costs a multiply; the product is simply not kept for clear bits.
    assign run_mul_now  = 1'b1;
    assign run_mul_next = 1'b1;
`else
    assign run_mul_now  = key_sh[0];
    assign run_mul_next = key_sh[1];
`endif

    assign launch  = (state == IDLE) && start && !start_q;
    assign mm_go   = (state inside {REDUCE, MUL, SQR}) && !issued;
    assign op_done = issued && mm_rdy;

    always_comb begin
        // NOTE: defaults first so every path assigns mm_a/mm_b and no latch is inferred.
        mm_a = data_q;
        mm_b = WIDTH'(1);
        case (state)
            MUL: begin
                mm_a = res;
                mm_b = base;
            end
            SQR: begin
                mm_a = base;
                mm_b = base;
            end
            default: ;
        endcase
    end

    mod_mul #(.WIDTH(WIDTH)) u_mod_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (mm_go),
        .a     (mm_a),
        .b     (mm_b),
        .N     (n_q),
        .p     (mm_p),
        .rdy   (mm_rdy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
            issued  <= 1'b0;
            data_q  <= '0;
            n_q     <= '0;
            key_sh  <= '0;
            res     <= '0;
            base    <= '0;
            bit_idx <= '0;
            result  <= '0;
            Done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            start_q <= start;
            Done    <= 1'b0;
            if (mm_go)
                issued <= 1'b1;
            case (state)
                IDLE: begin
                    busy <= launch;
                    if (launch) begin
                        data_q <= data;
                        n_q    <= N;
                        key_sh <= key;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (n_q < WIDTH'(2)) begin
                        res   <= '0;
                        state <= FIN;
                    end else begin
                        res   <= WIDTH'(1);
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (op_done) begin
                        base    <= mm_p;
                        issued  <= 1'b0;
                        bit_idx <= '0;
                        state   <= run_mul_now ? MUL : SQR;
                    end
                end
                MUL: begin
                    if (op_done) begin
                        if (key_sh[0])
                            res <= mm_p;
                        issued <= 1'b0;
                        state  <= SQR;
                    end
                end
                SQR: begin
                    if (op_done) begin
                        base   <= mm_p;
                        issued <= 1'b0;
                        key_sh <= key_sh >> 1;
                        if (bit_idx == LAST_BIT) begin
                            state <= FIN;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            state   <= run_mul_next ? MUL : SQR;
                        end
                    end
                end
                FIN: begin
                    result <= res;
                    Done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_decrypt.sv
// Directed self-checking bench for rsa_decrypt with hand-computed plaintexts and
// latencies; honours RSA_CONST_TIME_EN for the expected Done timing.
`timescale 1ns/1ps
module tb_rsa_decrypt;
    import rsa_pkg::*;

    localparam int W = DEFAULT_WIDTH;
`ifdef RSA_CONST_TIME_EN
    localparam int L_K7  = 93;
    localparam int L_K10 = 93;
    localparam int L_K0  = 93;
    localparam int L_K5  = 93;
    localparam int L_K3  = 93;
`else
    localparam int L_K7  = 72;
    localparam int L_K10 = 65;
    localparam int L_K0  = 51;
    localparam int L_K5  = 65;
    localparam int L_K3  = 65;
`endif
    localparam int L_K63  = 93;
    localparam int BUDGET = done_latency(W, W, 1'b0, 1'b1) + 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] data = '0;
    logic [W-1:0] N = '0;
    logic [W-1:0] key = '0;
    logic [W-1:0] result;
    logic         Done;
    logic         busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rsa_decrypt #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .data   (data),
        .N      (N),
        .key    (key),
        .result (result),
        .Done   (Done),
        .busy   (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] d, input logic [W-1:0] n, input logic [W-1:0] k);
        @(negedge clk);
        start = 1'b0;
        data  = d;
        N     = n;
        key   = k;
        @(negedge clk);
        start = 1'b1;
    endtask

    // Index of the edge after which Done is first seen; edge 0 samples the start edge.
    task automatic wait_done(input string tag, output int lat, output bit seen);
        seen = 1'b0;
        lat  = -1;
        for (int k = 0; k < BUDGET && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0)
                check({tag, "_busy_after_launch"}, busy, 1);
            if (Done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] d, input logic [W-1:0] n,
                          input logic [W-1:0] k, input int exp_res, input int exp_lat);
        int lat;
        bit seen;
        launch(d, n, k);
        wait_done(tag, lat, seen);
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, result, exp_res);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, Done, 0);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_result_hold"}, result, exp_res);
        start = 1'b0;
    endtask

    initial begin
        int done_cnt;
        int lat;
        logic [W-1:0] got;

        repeat (3) @(negedge clk);
        check("reset_result", result, 0);
        check("reset_done", Done, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;

        run_op("textbook", 6'd31, 6'd33, 6'd7, 4, L_K7);
        run_op("top_set", 6'd43, 6'd20, 6'd10, 9, L_K10);
        run_op("key_zero", 6'd5, 6'd33, 6'd0, 1, L_K0);
        run_op("n_one", 6'd45, 6'd1, 6'd27, 0, 2);
        run_op("n_zero", 6'd17, 6'd0, 6'd63, 0, 2);
        run_op("data_eq_n", 6'd63, 6'd63, 6'd5, 0, L_K5);
        run_op("data_gt_n", 6'd40, 6'd7, 6'd3, 6, L_K3);
        run_op("key_all_ones", 6'd2, 6'd61, 6'd63, 8, L_K63);

        // start held for 3 cycles, then a second rising edge while busy.
        @(negedge clk);
        start = 1'b0;
        data  = 6'd31;
        N     = 6'd33;
        key   = 6'd7;
        @(negedge clk);
        start = 1'b1;
        done_cnt = 0;
        lat      = -1;
        got      = '0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (Done) begin
                done_cnt++;
                if (lat < 0)
                    lat = c;
                got = result;
            end
            if (c == 2)
                start = 1'b0;
            else if (c == 10)
                start = 1'b1;
            else if (c == 12)
                start = 1'b0;
        end
        check("ctrl_single_done", done_cnt, 1);
        check("ctrl_latency", lat, L_K7);
        check("ctrl_result", got, 4);

        // Abort mid-operation with an asynchronous reset.
        launch(6'd43, 6'd20, 6'd10);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_result", result, 0);
        check("abort_done", Done, 0);
        check("abort_busy", busy, 0);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (Done)
                done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_idle_busy", busy, 0);
        run_op("after_abort", 6'd31, 6'd33, 6'd7, 4, L_K7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
